// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared constants and types for the 64-point FFT datapath
//                helpers: operand width, most-negative operand value and the
//                result-slot state encoding used by neg_share_arb.
//  Revision    : 1.0  initial release
// ============================================================================
package fft_pkg;

  // Operand / result width of the shared sign inverter.
  localparam int DATA_W = 16;

  // Most negative 16-bit value; its negation wraps back onto itself.
  localparam logic [DATA_W-1:0] MIN_NEG = 16'h8000;

  // Output slot occupancy.
  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_e;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Scans the request vector
//                starting at index ptr and wrapping modulo NREQ; the first
//                asserted request wins.
//  Ports       : req     in  NREQ  request vector
//                ptr     in  IDW   index the search starts from
//                en      in  1     grant enable (gates gnt only)
//                gnt     out NREQ  one-hot grant, all zero when en = 0
//                gnt_id  out IDW   encoded index of the winner
//                any     out 1     at least one request is asserted
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;
  logic           w_found;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Candidate index (ptr + k) mod NREQ without a divider: ptr < NREQ and
      // k < NREQ, so one conditional subtraction is enough.
      w_sum = {1'b0, ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NREQ)) begin
        w_sum = w_sum - (IDW+1)'(NREQ);
      end
      w_idx = w_sum[IDW-1:0];
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt_id     = w_idx;
        gnt[w_idx] = en;
      end
    end
  end

  assign any = w_found;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/sgninv_16b.sv
`default_nettype none
// ============================================================================
//  Module      : sgninv_16b
//  Description : 16-bit two's-complement sign inverter, y = ~a + 1, with the
//                carry out of the increment exposed. The carry is set only
//                for a = 0x0000, where ~a = 0xFFFF rolls over.
//  Ports       : i_a     in  16  operand
//                o_y     out 16  (~i_a + 1) mod 2^16
//                o_cout  out 1   carry out of the +1 increment
//  Revision    : 1.0  initial release
// ============================================================================
module sgninv_16b
  import fft_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  output logic [DATA_W-1:0] o_y,
  output logic              o_cout
);

  logic [DATA_W:0] w_sum;

  // Extend by one bit so the increment's carry lands in the MSB.
  assign w_sum  = {1'b0, ~i_a} + {{DATA_W{1'b0}}, 1'b1};
  assign o_y    = w_sum[DATA_W-1:0];
  assign o_cout = w_sum[DATA_W];

endmodule : sgninv_16b
`default_nettype wire

// File: rtl/neg_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : neg_share_arb
//  Description : Round-robin arbiter/sequencer sharing one 16-bit sign
//                inverter among NREQ requesters. One request is accepted per
//                cycle; its result (negated or passed through) is held in a
//                single registered output slot tagged with the requester ID.
//  Ports       : clk        in  1          rising-edge clock
//                rst        in  1          asynchronous active-high reset
//                req_valid  in  NREQ       per-requester valid
//                req_data   in  NREQ*16    operands, requester i at [16i+:16]
//                req_neg    in  NREQ       1 = negate, 0 = pass through
//                req_ready  out NREQ       per-requester accept (<= 1 high)
//                out_valid  out 1          result slot full
//                out_ready  in  1          downstream takes the result
//                out_data   out 16         result
//                out_cout   out 1          inverter carry (0 on pass)
//                out_ovf    out 1          negated operand was 0x8000
//                out_id     out IDW        requester the result belongs to
//  Revision    : 1.0  initial release
// ============================================================================
module neg_share_arb
  import fft_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2   // must equal clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_neg,
  output logic [NREQ-1:0]        req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_cout,
  output logic                   out_ovf,
  output logic [IDW-1:0]         out_id
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  slot_state_e       r_state;
  logic [IDW-1:0]    r_ptr;
  logic [DATA_W-1:0] r_data;
  logic              r_cout;
  logic              r_ovf;
  logic [IDW-1:0]    r_id;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic              w_can_accept;
  logic              w_en;
  logic [NREQ-1:0]   w_gnt;
  logic [IDW-1:0]    w_gnt_id;
  logic              w_any;
  logic              w_xfer;
  logic [IDW-1:0]    w_ptr_nxt;

  // The slot can take a new result when empty, or when the current one is
  // leaving this very cycle (no bubble on simultaneous drain and accept).
  assign w_can_accept = (r_state == S_EMPTY) || out_ready;

  // Reset is asynchronous, so grants are suppressed combinationally too.
  assign w_en = w_can_accept && !rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (r_ptr),
    .en     (w_en),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id),
    .any    (w_any)
  );

  assign req_ready = w_gnt;
  assign w_xfer    = w_any && w_en;

  // Pointer moves to the slot just after the winner so it has lowest priority.
  assign w_ptr_nxt = (w_gnt_id == IDW'(NREQ-1)) ? '0 : (w_gnt_id + 1'b1);

  // --------------------------------------------------------------------------
  // Operand selection and shared inverter
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_op;
  logic              w_neg;
  logic [DATA_W-1:0] w_inv_y;
  logic              w_inv_cout;
  logic [DATA_W-1:0] w_res;
  logic              w_res_cout;
  logic              w_res_ovf;

  // Constant-index mux keeps the selection free of variable part-selects.
  always_comb begin
    w_op  = '0;
    w_neg = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_id == IDW'(i)) begin
        w_op  = req_data[i*DATA_W +: DATA_W];
        w_neg = req_neg[i];
      end
    end
  end

  sgninv_16b u_sgninv (
    .i_a    (w_op),
    .o_y    (w_inv_y),
    .o_cout (w_inv_cout)
  );

  assign w_res      = w_neg ? w_inv_y : w_op;
  assign w_res_cout = w_neg && w_inv_cout;
  // -0x8000 is not representable; the inverter returns 0x8000 and this flags it.
  assign w_res_ovf  = w_neg && (w_op == MIN_NEG);

  // --------------------------------------------------------------------------
  // Output slot
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_ptr   <= '0;
      r_data  <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_id    <= '0;
    end else if (w_xfer) begin
      r_state <= S_FULL;
      r_ptr   <= w_ptr_nxt;
      r_data  <= w_res;
      r_cout  <= w_res_cout;
      r_ovf   <= w_res_ovf;
      r_id    <= w_gnt_id;
    end else if ((r_state == S_FULL) && out_ready) begin
      // Drained with nothing to replace it; payload left as-is, pointer held.
      r_state <= S_EMPTY;
    end
  end

  assign out_valid = (r_state == S_FULL);
  assign out_data  = r_data;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;
  assign out_id    = r_id;

endmodule : neg_share_arb
`default_nettype wire

// File: tb/tb_neg_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neg_share_arb
//  Description : Self-checking bench for neg_share_arb: a vector table for
//                single-request operand cases, directed sequences for
//                round-robin order, backpressure, pointer behaviour and
//                asynchronous reset, then constrained-random traffic compared
//                against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_neg_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*16-1:0]  req_data  = '0;
  logic [NREQ-1:0]     req_neg   = '0;
  logic [NREQ-1:0]     req_ready;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [15:0]         out_data;
  logic                out_cout;
  logic                out_ovf;
  logic [IDW-1:0]      out_id;

  always #5 clk = ~clk;

  neg_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_neg   (req_neg),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_id    (out_id)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: slot contents plus rotating priority start index
  // --------------------------------------------------------------------------
  bit          m_full;
  logic [15:0] m_data;
  bit          m_cout;
  bit          m_ovf;
  int          m_id;
  int          m_ptr;
  logic [3:0]  last_rdy;

  function automatic void m_reset();
    m_full = 0; m_data = 16'h0; m_cout = 0; m_ovf = 0; m_id = 0; m_ptr = 0;
  endfunction

  function automatic int m_winner();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    logic [3:0] r;
    int w;
    r = '0;
    if (!m_full || out_ready) begin
      w = m_winner();
      if (w >= 0) r[w] = 1'b1;
    end
    return r;
  endfunction

  function automatic void m_clock();
    int w;
    logic [15:0] a;
    w = m_winner();
    if ((!m_full || out_ready) && w >= 0) begin
      a = req_data[16*w +: 16];
      if (req_neg[w]) begin
        m_data = 16'((65536 - int'(a)) % 65536);
        m_cout = (a == 16'h0000);
        m_ovf  = (a == 16'h8000);
      end else begin
        m_data = a; m_cout = 0; m_ovf = 0;
      end
      m_id   = w;
      m_ptr  = (w + 1) % NREQ;
      m_full = 1;
    end else if (m_full && out_ready) begin
      m_full = 0;
    end
  endfunction

  // One clock: check grants before the edge, outputs just after it.
  task automatic step();
    @(negedge clk);
    last_rdy = req_ready;
    chk("req_ready", 32'(req_ready), 32'(m_ready()));
    m_clock();
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_full));
    if (m_full) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_id",   32'(out_id),   32'(m_id));
      chk("out_cout", 32'(out_cout), 32'(m_cout));
      chk("out_ovf",  32'(out_ovf),  32'(m_ovf));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '1;
    out_ready = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data",  32'(out_data),  32'h0);
    chk("rst_cout",  32'(out_cout),  32'h0);
    chk("rst_ovf",   32'(out_ovf),   32'h0);
    chk("rst_id",    32'(out_id),    32'h0);
    rst = 1'b0;
    req_valid = '0;
    m_reset();
  endtask

  function automatic logic [15:0] pick_op();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic [3:0]  valid;
    logic [63:0] data;
    logic [3:0]  neg;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_vld;
    logic [15:0] e_data;
    logic        e_cout;
    logic        e_ovf;
    logic [1:0]  e_id;
  } vec_t;

  vec_t vt[8];

  logic [15:0] snap_data;
  logic [1:0]  snap_id;

  initial begin
    vt[0] = '{4'b0100, 64'h0000_0005_0000_0000, 4'b0100, 1'b1, 4'b0100, 1'b1, 16'hFFFB, 1'b0, 1'b0, 2'd2};
    vt[1] = '{4'b0001, 64'h0000_0000_0000_0000, 4'b0001, 1'b1, 4'b0001, 1'b1, 16'h0000, 1'b1, 1'b0, 2'd0};
    vt[2] = '{4'b0010, 64'h0000_0000_8000_0000, 4'b0010, 1'b1, 4'b0010, 1'b1, 16'h8000, 1'b0, 1'b1, 2'd1};
    vt[3] = '{4'b1000, 64'h7FFF_0000_0000_0000, 4'b1000, 1'b1, 4'b1000, 1'b1, 16'h8001, 1'b0, 1'b0, 2'd3};
    vt[4] = '{4'b0100, 64'h0000_0000_0000_0000, 4'b0000, 1'b1, 4'b0100, 1'b1, 16'h0000, 1'b0, 1'b0, 2'd2};
    vt[5] = '{4'b0001, 64'h0000_0000_0000_8000, 4'b0000, 1'b1, 4'b0001, 1'b1, 16'h8000, 1'b0, 1'b0, 2'd0};
    vt[6] = '{4'b0010, 64'h0000_0000_7FFF_0000, 4'b0000, 1'b1, 4'b0010, 1'b1, 16'h7FFF, 1'b0, 1'b0, 2'd1};
    vt[7] = '{4'b0000, 64'h0000_0000_0000_0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0};

    #2;
    do_reset();

    // Single-request operand cases.
    for (int r = 0; r < 8; r++) begin
      req_valid = vt[r].valid;
      req_data  = vt[r].data;
      req_neg   = vt[r].neg;
      out_ready = vt[r].ordy;
      step();
      chk("tbl_ready", 32'(last_rdy),  32'(vt[r].e_rdy));
      chk("tbl_valid", 32'(out_valid), 32'(vt[r].e_vld));
      if (vt[r].e_vld) begin
        chk("tbl_data", 32'(out_data), 32'(vt[r].e_data));
        chk("tbl_cout", 32'(out_cout), 32'(vt[r].e_cout));
        chk("tbl_ovf",  32'(out_ovf),  32'(vt[r].e_ovf));
        chk("tbl_id",   32'(out_id),   32'(vt[r].e_id));
      end
    end

    // All requesters valid: strict rotation, one result per cycle.
    do_reset();
    req_valid = 4'hF;
    req_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    req_neg   = 4'b0101;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_id",     32'(out_id), 32'(k % NREQ));
      chk("rr_onehot", 32'($countones(last_rdy)), 32'd1);
      chk("rr_valid",  32'(out_valid), 32'd1);
    end

    // Backpressure: slot frozen, no grants, pointer held.
    do_reset();
    req_valid = 4'hF;
    out_ready = 1'b1;
    step();
    snap_data = out_data;
    snap_id   = out_id;
    chk("bp_first_id", 32'(out_id), 32'd0);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_ready", 32'(last_rdy),  32'h0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data",  32'(out_data),  32'(snap_data));
      chk("bp_id",    32'(out_id),    32'(snap_id));
    end
    out_ready = 1'b1;
    step();
    chk("bp_resume_ready", 32'(last_rdy), 32'b0010);
    chk("bp_resume_id",    32'(out_id),   32'd1);
    chk("bp_resume_valid", 32'(out_valid), 32'd1);

    // Lone requester 1 streams every cycle; requester 3 then wins via ptr=2.
    do_reset();
    req_valid = 4'b0010;
    req_data  = 64'h0000_0000_1234_0000;
    req_neg   = 4'b0000;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("solo_ready", 32'(last_rdy), 32'b0010);
      chk("solo_id",    32'(out_id),   32'd1);
      chk("solo_data",  32'(out_data), 32'h1234);
    end
    req_valid = 4'b1010;
    step();
    chk("late3_ready", 32'(last_rdy), 32'b1000);
    chk("late3_id",    32'(out_id),   32'd3);

    // Asynchronous reset while FULL and stalled.
    req_valid = 4'hF;
    out_ready = 1'b0;
    step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_ready", 32'(req_ready), 32'h0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end
    req_valid = 4'hF;
    step();
    chk("post_rst_ptr0", 32'(last_rdy), 32'b0001);

    // Randomized traffic; data and neg held while a request is pending.
    do_reset();
    last_rdy = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || last_rdy[i]) begin
          req_valid[i]          = ($urandom_range(0, 9) < 6);
          req_data[16*i +: 16]  = pick_op();
          req_neg[i]            = 1'($urandom_range(0, 1));
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_neg_share_arb
`default_nettype wire

// File: doc/neg_share_arb.md
# neg_share_arb

Round-robin arbiter and sequencer that shares one 16-bit two's-complement sign inverter among NREQ requesters in the 64-point FFT datapath. Butterfly and twiddle stages use it for trivial-twiddle negations, such as multiplication by -1 or -j. Each requester presents a valid/ready request carrying a 16-bit operand and a negate-enable bit. The block grants one request per cycle, computes the result through the shared inverter, and holds it in a single registered output slot tagged with the requester ID.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester ID; must equal clog2(NREQ)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_data  in  NREQ*16  packed operands; requester i uses bits [16i+15:16i]
- req_neg  in  NREQ  per-requester select: 1 = negate, 0 = pass through
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- out_valid  out  1  result slot full
- out_ready  in  1  downstream accepts the result
- out_data  out  16  result
- out_cout  out  1  inverter carry out; 0 when req_neg = 0
- out_ovf  out  1  set when a negated operand is 0x8000
- out_id  out  IDW  requester index the result belongs to

## Operation
- Output slot has two states: EMPTY (out_valid = 0) and FULL (out_valid = 1).
- can_accept = EMPTY, or (FULL and out_ready).
- Arbitration: a round-robin search starts at pointer ptr and picks the first i with req_valid[i]. req_ready[i] = can_accept and (i is that winner). This is purely combinational from req_valid, ptr and state.
- Transfer on requester i means req_valid[i] and req_ready[i].
- On transfer:
  - The slot loads i, the computed result, cout and ovf.
  - The state becomes or stays FULL.
  - ptr <= (i+1) mod NREQ.
- Drain without a new transfer: FULL and out_ready and no req_valid. The state goes to EMPTY and ptr is unchanged.
- FULL and not out_ready: the slot holds, all req_ready = 0, and ptr is held.
- Result computation:
  - Negate: out_data = (~A + 1) mod 2^16, and out_cout is the carry out of that add. out_cout = 1 only for A = 0x0000. out_ovf = (A == 0x8000), and out_data = 0x8000 in that case.
  - Pass: out_data = A, out_cout = 0, out_ovf = 0.
- Requesters must hold req_data and req_neg stable while req_valid is high and not yet accepted. The block does not check this.
- No starvation: a continuously asserted request is granted within NREQ accepted transfers.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, out_cout = 0, out_ovf = 0, out_id = 0.
  - ptr = 0, state EMPTY.
  - req_ready is forced to 0 while rst is high.
- Latency: request accepted at edge N, result visible on out_* after edge N. That is one cycle.
- Throughput: one result per cycle while out_ready stays high, including back-to-back accepts from the same requester when it is the only one active.
- Simultaneous drain and accept in the same cycle: the slot is replaced with no bubble.
- Reset asserted mid-operation: the pending result is discarded and the slot goes EMPTY immediately (asynchronous). No result is emitted after reset is released until a new transfer.
- Output signals change only on the clk edge or on rst. req_ready depends combinationally on out_ready.

## Structure
- fft_pkg holds:
  - the DATA_W = 16 constant
  - the state enum {S_EMPTY, S_FULL}
  - the MIN_NEG = 16'h8000 constant
- Sub-module rr_arbiter (NREQ, IDW):
  - inputs: req, ptr, en
  - outputs: one-hot gnt, encoded gnt_id, any
- Result path: one instance of the team's sgninv_16b fed by the muxed operand. Its output is selected against the pass-through value by the muxed req_neg bit.

## Test plan
- Reset then a single request: i=2, A=0x0005, neg=1, out_ready=1.
  - req_ready[2] high the same cycle.
  - Next cycle: out_valid=1, out_data=0xFFFB, out_id=2, out_cout=0, out_ovf=0.
- Edge operands with neg=1, each on its own request:
  - 0x0000 gives 0x0000 and cout=1.
  - 0x8000 gives 0x8000 and ovf=1.
  - 0x7FFF gives 0x8001.
  - The same operands with neg=0 pass unchanged, with cout=0 and ovf=0.
- All 4 requesters valid continuously, out_ready=1:
  - out_id sequence 0,1,2,3,0,1,… with one result per cycle.
  - Exactly one req_ready bit high per cycle.
- Backpressure:
  - Slot FULL and out_ready=0 for 5 cycles: out_* stable, req_ready all 0, ptr held.
  - out_ready then rises: the slot is replaced by the next grant the same cycle.
- Only requester 1 active, out_ready=1: accepted every cycle, out_id=1 each cycle.
  - Requester 3 then asserts: it is granted at the next accept, because ptr=2 makes the search order 2,3,0,1.
- rst pulsed while FULL and out_ready=0:
  - out_valid drops asynchronously and ptr returns to 0.
  - After release with no requests: out_valid stays 0.
